// File: rtl/ctrl_resp_pkg.sv
// Shared types and helpers for the control request responder.
// Latency: n/a (types, constant functions only).
// Backpressure: n/a.
package ctrl_resp_pkg;

    typedef logic [31:0] stat_cnt_t;

    function automatic int pending_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth must be a power of two so the pointers can simply wrap.
    function automatic bit params_legal(input int width, input int depth, input int max_pending);
        return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) && (max_pending >= 1);
    endfunction

endpackage

// File: rtl/ctrl_resp_fifo.sv
// Synchronous FIFO with look-ahead head data and registered count/full/empty.
// Latency: a write is visible at the head one cycle later.
// Backpressure: writes while full and reads while empty are ignored.
module ctrl_resp_fifo
    import ctrl_resp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_dat,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_dat,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              do_wr;
    logic              do_rd;

    assign do_wr  = wr_en && !full;
    assign do_rd  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage carries no reset; the cleared count makes old contents unreachable.
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/ctrl_rq_responder.sv
// Returns one FIFO'd control word per request, queueing requests while empty; CTRL_RESP_STATS_EN adds counters.
// Latency: request to VLD/data 1 cycle with data present; write to VLD 2 cycles when requests wait.
// Backpressure: none to the requester; excess requests or full-FIFO writes are dropped and set OVERFLOW.
module ctrl_rq_responder
    import ctrl_resp_pkg::*;
#(
    parameter int CTRL_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_PENDING     = 15
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [CTRL_DATA_WIDTH-1:0]       WR_DATA,
    input  logic                             WR_EN,
    output logic                             WR_FULL,
    input  logic                             CTRL_DATA_IN_RQ,
    output logic [CTRL_DATA_WIDTH-1:0]       CTRL_DATA_IN,
    output logic                             CTRL_DATA_IN_VLD,
    output logic [pending_w(MAX_PENDING)-1:0] PENDING,
    output logic [count_w(FIFO_DEPTH)-1:0]   FIFO_COUNT,
    input  logic                             OVF_CLR,
    output logic                             OVERFLOW
`ifdef CTRL_RESP_STATS_EN
    ,
    output stat_cnt_t                        SERVED_CNT,
    output stat_cnt_t                        STALL_CNT
`endif
);

    localparam int PW = pending_w(MAX_PENDING);

    if (!params_legal(CTRL_DATA_WIDTH, FIFO_DEPTH, MAX_PENDING)) begin : g_param_check
        $error("ctrl_rq_responder: illegal CTRL_DATA_WIDTH/FIFO_DEPTH/MAX_PENDING");
    end

    logic [CTRL_DATA_WIDTH-1:0] head_dat;
    logic                       fifo_empty;
    logic                       serve;
    logic                       wr_drop;
    logic                       rq_drop;
    logic [PW-1:0]              pending_nxt;

    ctrl_resp_fifo #(
        .WIDTH (CTRL_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .wr_en  (WR_EN),
        .wr_dat (WR_DATA),
        .rd_en  (serve),
        .rd_dat (head_dat),
        .count  (FIFO_COUNT),
        .full   (WR_FULL),
        .empty  (fifo_empty)
    );

    assign serve   = ((PENDING != '0) || CTRL_DATA_IN_RQ) && !fifo_empty;
    assign wr_drop = WR_EN && WR_FULL;
    assign rq_drop = CTRL_DATA_IN_RQ && !serve && (PENDING == PW'(MAX_PENDING));

    // A serve that coincides with a new request leaves the backlog unchanged.
    always_comb begin
        pending_nxt = PENDING;
        if (CTRL_DATA_IN_RQ && !serve && !rq_drop) begin
            pending_nxt = PENDING + PW'(1);
        end else if (!CTRL_DATA_IN_RQ && serve) begin
            pending_nxt = PENDING - PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PENDING          <= '0;
            CTRL_DATA_IN     <= '0;
            CTRL_DATA_IN_VLD <= 1'b0;
            OVERFLOW         <= 1'b0;
        end else begin
            PENDING          <= pending_nxt;
            CTRL_DATA_IN_VLD <= serve;
            if (serve) begin
                CTRL_DATA_IN <= head_dat;
            end
            if (wr_drop || rq_drop) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

`ifdef CTRL_RESP_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SERVED_CNT <= '0;
            STALL_CNT  <= '0;
        end else begin
            if (serve) begin
                SERVED_CNT <= SERVED_CNT + 32'd1;
            end
            if ((PENDING != '0) && fifo_empty) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ctrl_rq_responder.md
# ctrl_rq_responder

Responder end of the control request/valid handshake: a consumer asserts `CTRL_DATA_IN_RQ` and this block returns one control word on `CTRL_DATA_IN` qualified by `CTRL_DATA_IN_VLD`. Control words are loaded by a producer through a simple write port into an internal FIFO. Requests that arrive while the FIFO is empty are counted and served in order once data arrives. It sits between a ticket/control-word producer and any DUT that pulls control data via the `dut_in`-style request interface.

## Interface
- `CTRL_DATA_WIDTH`, 8, width of one control word
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `MAX_PENDING`, 15, max outstanding unserved requests; ≥ 1
- Clock is `CLK`; reset is `RESET`, asynchronous, active-low.
- `CLK` in 1: clock, all logic on rising edge
- `RESET` in 1: asynchronous active-low reset
- `WR_DATA` in `CTRL_DATA_WIDTH`: control word from producer
- `WR_EN` in 1: write strobe
- `WR_FULL` out 1: FIFO full, write ignored
- `CTRL_DATA_IN_RQ` in 1: one request per cycle high
- `CTRL_DATA_IN` out `CTRL_DATA_WIDTH`: returned control word
- `CTRL_DATA_IN_VLD` out 1: `CTRL_DATA_IN` valid, one-cycle pulse per served request
- `PENDING` out `$clog2(MAX_PENDING+1)`: outstanding request count
- `FIFO_COUNT` out `$clog2(FIFO_DEPTH+1)`: words stored
- `OVF_CLR` in 1: clears `OVERFLOW`
- `OVERFLOW` out 1: sticky error flag

## Operation
- Write: accepted when `WR_EN && !WR_FULL`. `WR_EN` while `WR_FULL` drops the word and sets `OVERFLOW`.
- Request: each cycle with `CTRL_DATA_IN_RQ`=1 is exactly one request. There is no back-pressure to the requester.
- Serve condition in cycle t: `(PENDING>0 || CTRL_DATA_IN_RQ) && FIFO_COUNT>0`. At most one serve per cycle. A serve pops the FIFO head.
- `PENDING_next = PENDING + RQ - serve`.
- If `PENDING==MAX_PENDING`, `RQ`=1, and no serve occurs, the request is dropped, `PENDING` holds, and `OVERFLOW` is set.
- Service is strictly FIFO order. Requests are anonymous, so each serve satisfies the oldest outstanding request.
- `OVERFLOW` is set by either overflow cause and cleared by `OVF_CLR`. When set and clear occur in the same cycle, set wins.
- Write and serve in the same cycle: `FIFO_COUNT` is unchanged.
- `WR_FULL` is `FIFO_COUNT==FIFO_DEPTH` from registered state. A pop in the same cycle does not unblock a write.

## Timing
- Reset values (async assert, sync release): `CTRL_DATA_IN`=0, `CTRL_DATA_IN_VLD`=0, `WR_FULL`=0, `PENDING`=0, `FIFO_COUNT`=0, `OVERFLOW`=0. FIFO contents are discarded.
- Request-to-data latency is 1 cycle when data is present: `RQ` at edge t gives `VLD`=1 and the data after edge t+1.
- Write-to-visible latency is 1 cycle. With `PENDING>0` and an empty FIFO, a write at t gives `VLD` at t+2.
- `CTRL_DATA_IN` is registered. It holds its last value when `VLD`=0.
- Back-to-back `RQ` with a non-empty FIFO gives `VLD` every cycle, with `PENDING` staying 0.
- Reset mid-operation drops all pending requests and stored words. No `VLD` is issued after reset until a new serve condition occurs.

## Configuration
- `CTRL_RESP_STATS_EN` defined: adds output `SERVED_CNT` and output `STALL_CNT`, both 32 bits, wrapping, reset to 0.
  - `SERVED_CNT` increments per `VLD`.
  - `STALL_CNT` increments each cycle with `PENDING>0 && FIFO_COUNT==0`.
- `CTRL_RESP_STATS_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Package `ctrl_resp_pkg` holds:
  - width helper functions for `PENDING` and `FIFO_COUNT`;
  - the typedef for the stats counter, 32-bit unsigned;
  - the elaboration-time parameter legality checks.
- Sub-module `ctrl_resp_fifo`: synchronous FIFO with power-of-two depth and wrapping pointers. It provides registered `count`, `full` and `empty`, and first-word look-ahead head data.
- The top level holds the pending counter, serve logic, output register, overflow flag and the optional stats.

## Test plan
- Load 0x11, 0x22, 0x33, idle 2 cycles, then `RQ` for 3 consecutive cycles → `VLD` on 3 consecutive cycles, 1 cycle after each `RQ`, data 0x11, 0x22, 0x33; `PENDING` stays 0.
- Empty FIFO, `RQ` for 4 cycles → `PENDING`=4, no `VLD`. Then write 0xA5 → `VLD` with 0xA5 2 cycles after the write and `PENDING`=3.
- `MAX_PENDING`=15: 16 `RQ` cycles with the FIFO empty → `PENDING`=15, `OVERFLOW`=1. Then 16 writes → exactly 15 `VLD` pulses, and `FIFO_COUNT`=1.
- Fill 16 words, write 0xFF with `WR_FULL`=1 → word dropped, `OVERFLOW`=1. Drain gives the 16 original words with no 0xFF. `OVF_CLR` pulse → `OVERFLOW`=0.
- Assert `RESET`=0 with `PENDING`=3 and `FIFO_COUNT`=5 → all outputs are 0 immediately (asynchronously). After release, a write followed by `RQ` gives exactly 1 `VLD`.
- With `CTRL_RESP_STATS_EN`: the scenario-2 sequence gives `STALL_CNT`=4 (cycles with `PENDING>0` and an empty FIFO, up to and including the write cycle) and `SERVED_CNT`=1.
